// File: rtl/ppl_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
// Holds the hold/clear code encodings, the FSM state type and the
// RUN-state priority resolver used by ppl_ctrl.
//   Hold codes are cumulative : NONE, ID (PC+IF/ID), EX (+ID/EX), PPL (all)
//   Clear codes               : NONE, ID (IF/ID), EX (ID/EX), PPL (IF/ID+ID/EX)
package ppl_ctrl_pkg;

  localparam int unsigned HOLD_W  = 2;
  localparam int unsigned CLEAR_W = 2;
  localparam int unsigned CNT_W   = 8;

  localparam logic [HOLD_W-1:0] HOLD_NONE = 2'd0;
  localparam logic [HOLD_W-1:0] HOLD_ID   = 2'd1;
  localparam logic [HOLD_W-1:0] HOLD_EX   = 2'd2;
  localparam logic [HOLD_W-1:0] HOLD_PPL  = 2'd3;

  localparam logic [CLEAR_W-1:0] CLEAR_NONE = 2'd0;
  localparam logic [CLEAR_W-1:0] CLEAR_ID   = 2'd1;
  localparam logic [CLEAR_W-1:0] CLEAR_EX   = 2'd2;
  localparam logic [CLEAR_W-1:0] CLEAR_PPL  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_INT_ENTER = 2'd2
  } state_t;

  // Decision taken by the RUN priority chain when memory is not busy
  typedef struct packed {
    logic [HOLD_W-1:0]  hold;
    logic [CLEAR_W-1:0] clear;
    logic               bubble;
    logic               take_int;
  } run_dec_t;

  // RUN priority below mem_busy: jump flush > load-use bubble > interrupt
  function automatic run_dec_t run_decide(input logic jump,
                                          input logic load_use,
                                          input logic int_ok);
    run_dec_t d;
    d = '0;
    if (jump) begin
      d.clear = CLEAR_PPL;
    end else if (load_use) begin
      d.hold   = HOLD_ID;
      d.clear  = CLEAR_EX;
      d.bubble = 1'b1;
    end else if (int_ok) begin
      d.clear    = CLEAR_PPL;
      d.take_int = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/ppl_hazard_det.sv
// Load-use hazard detector.
// Flags when the load currently in EX writes a register that the
// instruction in ID reads. Register 0 is not exempt.
// Ports:
//   id_rs1, id_rs2         in  source register indices of the ID instruction
//   id_uses_rs1/rs2        in  source field is actually read
//   ex_rd                  in  destination index of the EX instruction
//   ex_mem_rd              in  EX instruction is a load
//   load_use               out combinational hazard flag
module ppl_hazard_det (
  input  logic [2:0] id_rs1,
  input  logic [2:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [2:0] ex_rd,
  input  logic       ex_mem_rd,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
  assign load_use = ex_mem_rd & (rs1_hit | rs2_hit);

endmodule

// File: rtl/ppl_ctrl.sv
// Central pipeline sequencer for the 16-bit pipelined core.
// Drives stage hold/clear codes, resolves load-use stalls, jump flushes,
// multi-cycle memory waits (with timeout) and interrupt entry with PC
// redirect and EPC capture. Hold/clear/redirect/pulse outputs are
// combinational from state and inputs; epc is a register.
// Optional feature macro: PPL_CTRL_PERF_EN adds saturating stall_cnt and
// flush_cnt counters (ports exist only when the macro is defined).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_rs1/id_rs2            source register indices of ID instruction
//   id_uses_rs1/id_uses_rs2  source fields valid
//   id_inst_addr             PC of ID instruction (EPC source)
//   ex_rd, ex_mem_rd         EX destination index / EX is a load
//   ex_jump                  EX resolved a taken jump/branch
//   mem_busy                 data memory not ready
//   int_req, int_en          level interrupt request / global enable
//   hold_flag, clear_flag    stage hold and clear codes
//   pc_redirect, pc_target   load pc_target into PC this cycle
//   epc                      saved interrupt return address
//   int_ack                  one-cycle interrupt acceptance pulse
//   mem_timeout              one-cycle memory wait timeout pulse
//   stall_cnt, flush_cnt     (PPL_CTRL_PERF_EN only) saturating counters
module ppl_ctrl
  import ppl_ctrl_pkg::*;
#(
  parameter int unsigned     DW      = 16,
  parameter logic [DW-1:0]   INT_VEC = DW'(16'h0004),
  parameter int unsigned     MEM_TO  = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         id_rs1,
  input  logic [2:0]         id_rs2,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic [DW-1:0]      id_inst_addr,
  input  logic [2:0]         ex_rd,
  input  logic               ex_mem_rd,
  input  logic               ex_jump,
  input  logic               mem_busy,
  input  logic               int_req,
  input  logic               int_en,
  output logic [HOLD_W-1:0]  hold_flag,
  output logic [CLEAR_W-1:0] clear_flag,
  output logic               pc_redirect,
  output logic [DW-1:0]      pc_target,
  output logic [DW-1:0]      epc,
  output logic               int_ack,
  output logic               mem_timeout
`ifdef PPL_CTRL_PERF_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic [DW-1:0]    epc_q;
  logic [DW-1:0]    epc_d;
  logic             bubble_q;
  logic             bubble_d;
  logic             load_use;
  logic             use_run;
  run_dec_t         run_dec;

  // Load-use compare lives in its own block
  ppl_hazard_det u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_rd   (ex_mem_rd),
    .load_use    (load_use)
  );

  // Wait cycle number of the current cycle (previous held cycles + 1)
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

  // The cycle right after a bubble still sees the same ID/EX pair, so
  // neither a second bubble nor interrupt entry is allowed there.
  assign run_dec = run_decide(ex_jump,
                              load_use & ~bubble_q,
                              int_req & int_en & ~bubble_q);

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    epc_d       = epc_q;
    bubble_d    = 1'b0;
    use_run     = 1'b0;
    hold_flag   = HOLD_NONE;
    clear_flag  = CLEAR_NONE;
    pc_redirect = 1'b0;
    pc_target   = '0;
    int_ack     = 1'b0;
    mem_timeout = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          hold_flag = HOLD_PPL;
          state_d   = ST_MEM_WAIT;
          cnt_d     = CNT_W'(1);
        end else begin
          use_run = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_busy) begin
          // Memory ready: this cycle behaves as a RUN cycle
          use_run = 1'b1;
        end else if (cnt_inc >= (CNT_W+1)'(MEM_TO)) begin
          mem_timeout = 1'b1;
          state_d     = ST_RUN;
          cnt_d       = '0;
        end else begin
          hold_flag = HOLD_PPL;
          cnt_d     = cnt_inc[CNT_W-1:0];
        end
      end
      ST_INT_ENTER: begin
        int_ack = 1'b1;
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (use_run) begin
      hold_flag   = run_dec.hold;
      clear_flag  = run_dec.clear;
      bubble_d    = run_dec.bubble;
      cnt_d       = '0;
      state_d     = ST_RUN;
      if (run_dec.take_int) begin
        pc_redirect = 1'b1;
        pc_target   = INT_VEC;
        epc_d       = id_inst_addr;
        state_d     = ST_INT_ENTER;
      end
    end

    // Outputs sit at their reset values while reset is asserted
    if (rst) begin
      hold_flag   = HOLD_NONE;
      clear_flag  = CLEAR_NONE;
      pc_redirect = 1'b0;
      pc_target   = '0;
      int_ack     = 1'b0;
      mem_timeout = 1'b0;
    end
  end

  // Sequencer state, wait counter, EPC and bubble marker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      epc_q    <= '0;
      bubble_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      epc_q    <= epc_d;
      bubble_q <= bubble_d;
    end
  end

  assign epc = epc_q;

`ifdef PPL_CTRL_PERF_EN
  // Saturating stall/flush cycle counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((hold_flag != HOLD_NONE) && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if ((clear_flag != CLEAR_NONE) && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ppl_ctrl.sv
// Scoreboard bench for ppl_ctrl: stimulus pushes model expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ppl_ctrl;
  import ppl_ctrl_pkg::*;

  localparam int unsigned DW     = 16;
  localparam int          MEM_TO = 8;
  localparam logic [15:0] VEC    = 16'h0004;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2;
  logic [DW-1:0] id_inst_addr;
  logic          ex_mem_rd, ex_jump, mem_busy, int_req, int_en;
  logic [1:0]    hold_flag, clear_flag;
  logic          pc_redirect, int_ack, mem_timeout;
  logic [DW-1:0] pc_target, epc;
`ifdef PPL_CTRL_PERF_EN
  logic [15:0]   stall_cnt, flush_cnt;
`endif

  ppl_ctrl #(.DW(DW), .INT_VEC(VEC), .MEM_TO(MEM_TO)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_inst_addr(id_inst_addr), .ex_rd(ex_rd), .ex_mem_rd(ex_mem_rd),
    .ex_jump(ex_jump), .mem_busy(mem_busy), .int_req(int_req), .int_en(int_en),
    .hold_flag(hold_flag), .clear_flag(clear_flag),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .epc(epc),
    .int_ack(int_ack), .mem_timeout(mem_timeout)
`ifdef PPL_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] rs1, rs2, rd;
    logic       u1, u2, ld, jmp, busy, irq, ien;
    logic [15:0] addr;
  } stim_t;

  typedef struct {
    logic [1:0]  hold, clear;
    logic        redir, ack, tout;
    logic [15:0] tgt, epc;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Reference model state: cycles held so far in a memory wait, pending
  // acknowledge, whether last cycle was a bubble, saved return address.
  int          m_wait = 0;
  bit          m_ack_due = 0;
  bit          m_prev_bub = 0;
  logic [15:0] m_epc = '0;

  function automatic exp_t model(input stim_t s);
    exp_t e;
    bit   hazard;
    e.hold = HOLD_NONE; e.clear = CLEAR_NONE; e.redir = 0; e.ack = 0;
    e.tout = 0; e.tgt = '0; e.epc = m_epc;
    if (s.rst) begin
      m_wait = 0; m_ack_due = 0; m_prev_bub = 0; m_epc = '0;
      e.epc = '0;
      return e;
    end
    if (m_ack_due) begin
      e.ack = 1; m_ack_due = 0; m_prev_bub = 0;
    end else if (s.busy) begin
      m_prev_bub = 0;
      if (m_wait > 0 && m_wait + 1 >= MEM_TO) begin
        e.tout = 1; m_wait = 0;
      end else begin
        e.hold = HOLD_PPL; m_wait = m_wait + 1;
      end
    end else begin
      m_wait = 0;
      hazard = s.ld && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      if (s.jmp) begin
        e.clear = CLEAR_PPL; m_prev_bub = 0;
      end else if (hazard && !m_prev_bub) begin
        e.hold = HOLD_ID; e.clear = CLEAR_EX; m_prev_bub = 1;
      end else if (s.irq && s.ien && !m_prev_bub) begin
        e.clear = CLEAR_PPL; e.redir = 1; e.tgt = VEC;
        m_epc = s.addr; m_ack_due = 1; m_prev_bub = 0;
      end else begin
        m_prev_bub = 0;
      end
    end
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.u1 = 0; s.u2 = 0;
    s.ld = 0; s.jmp = 0; s.busy = 0; s.irq = 0; s.ien = 0; s.addr = '0;
    return s;
  endfunction

  // Drive one cycle of inputs just after the clock edge and queue expectation
  task automatic apply(input stim_t s);
    @(posedge clk);
    #1;
    rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.rd;
    id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; ex_mem_rd = s.ld;
    ex_jump = s.jmp; mem_busy = s.busy; int_req = s.irq; int_en = s.ien;
    id_inst_addr = s.addr;
    sb.push_back(model(s));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("hold_flag",   32'(hold_flag),   32'(e.hold));
        chk("clear_flag",  32'(clear_flag),  32'(e.clear));
        chk("pc_redirect", 32'(pc_redirect), 32'(e.redir));
        chk("pc_target",   32'(pc_target),   32'(e.tgt));
        chk("epc",         32'(epc),         32'(e.epc));
        chk("int_ack",     32'(int_ack),     32'(e.ack));
        chk("mem_timeout", 32'(mem_timeout), 32'(e.tout));
      end
    end
  end

  initial begin
    stim_t s;
    int    burst;
    rst = 1; id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mem_rd = 0; ex_jump = 0; mem_busy = 0; int_req = 0; int_en = 0;
    id_inst_addr = '0;

    // Reset and idle
    s = idle(); s.rst = 1;
    repeat (3) apply(s);
    s = idle();
    repeat (2) apply(s);

    // Load-use on rs2 held static: bubble, free cycle, bubble again
    s = idle(); s.ld = 1; s.rd = 3; s.rs2 = 3; s.u2 = 1;
    repeat (3) apply(s);
    s = idle(); apply(s);

    // Load-use on r0 via rs1
    s = idle(); s.ld = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1;
    apply(s);
    s = idle(); apply(s);

    // Jump together with load-use: flush only
    s = idle(); s.ld = 1; s.rd = 3; s.rs2 = 3; s.u2 = 1; s.jmp = 1;
    apply(s);
    s = idle(); apply(s);

    // Memory busy for 4 cycles, then ready
    s = idle(); s.busy = 1;
    repeat (4) apply(s);
    s = idle(); repeat (2) apply(s);

    // Memory stuck busy: timeout on the MEM_TO-th cycle
    s = idle(); s.busy = 1;
    repeat (12) apply(s);
    s = idle(); apply(s);

    // Interrupt entry from 0x0120, handler then clears int_en
    s = idle(); s.irq = 1; s.ien = 1; s.addr = 16'h0120;
    apply(s);
    s.ien = 0;
    repeat (2) apply(s);
    s = idle(); apply(s);

    // Interrupt coinciding with jump: taken the following cycle
    s = idle(); s.irq = 1; s.ien = 1; s.jmp = 1; s.addr = 16'h0200;
    apply(s);
    s.jmp = 0; s.addr = 16'h0204;
    apply(s);
    s.ien = 0;
    apply(s);
    s = idle(); apply(s);

    // Interrupt during a load-use bubble and the cycle after it
    s = idle(); s.irq = 1; s.ien = 1; s.ld = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
    s.addr = 16'h0300;
    repeat (2) apply(s);
    s.ld = 0;
    apply(s);
    s = idle(); repeat (2) apply(s);

    // Reset pulse in the middle of a memory wait
    s = idle(); s.busy = 1;
    repeat (3) apply(s);
    s.rst = 1;
    repeat (2) apply(s);
    s.rst = 0;
    repeat (2) apply(s);
    s = idle(); apply(s);

    // Randomized traffic with memory-busy bursts
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      if (burst > 0) begin
        s.busy = 1; burst--;
      end else if ($urandom_range(0, 9) == 0) begin
        burst = int'($urandom_range(1, 12));
      end
      s.ld   = ($urandom_range(0, 9) < 4);
      s.rd   = 3'($urandom_range(0, 7));
      s.rs1  = 3'($urandom_range(0, 7));
      s.rs2  = 3'($urandom_range(0, 7));
      s.u1   = 1'($urandom_range(0, 1));
      s.u2   = 1'($urandom_range(0, 1));
      s.jmp  = ($urandom_range(0, 9) == 0);
      s.irq  = ($urandom_range(0, 4) == 0);
      s.ien  = 1'($urandom_range(0, 1));
      s.addr = 16'($urandom);
      s.rst  = ($urandom_range(0, 499) == 0);
      apply(s);
    end
    s = idle(); apply(s);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
